// File: rtl/cp0_exc.sv
// CP0 for the MIPS core: Count/Compare timer, Status, Cause, EPC, PRId, exception entry/ERET.
// Optional BadVAddr register (reg 8) and badvaddr port when CP0_BADVADDR_EN is defined.
module cp0_exc #(
   parameter int          HW_IRQ    = 6,
   parameter int          COUNT_DIV = 2,
   parameter logic [31:0] PRID_VAL  = 32'h0001_8000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cp0_w,
   input  logic [4:0]        a1,
   input  logic [31:0]       wd,
   output logic [31:0]       rd1,
   input  logic [31:0]       pc,
   input  logic              bd,
   input  logic              exc_req,
   input  logic [4:0]        exc_code,
   input  logic              eret,
   input  logic [HW_IRQ-1:0] hw_int,
`ifdef CP0_BADVADDR_EN
   input  logic [31:0]       badvaddr,
`endif
   output logic              irq,
   output logic [31:0]       epc_out,
   output logic              exl
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);

   logic [31:0]       count_reg;
   logic [31:0]       compare_reg;
   logic [PW-1:0]     presc_reg;
   logic [7:0]        im_reg;
   logic              exl_reg;
   logic              ie_reg;
   logic              bd_reg;
   logic              ti_reg;
   logic [1:0]        ip_sw_reg;
   logic [HW_IRQ-1:0] hw_int_reg;
   logic [4:0]        exc_code_reg;
   logic [31:0]       epc_reg;
   logic [7:0]        ip;

   // mtc0 is dropped whenever an exception or ERET claims the same cycle
   logic        wr_en;
   logic        wr_count;
   logic        wr_compare;
   logic        tick;
   logic [31:0] count_inc;
   logic        ti_set;

   assign wr_en      = cp0_w & ~exc_req & ~eret;
   assign wr_count   = wr_en && (a1 == 5'd9);
   assign wr_compare = wr_en && (a1 == 5'd11);
   assign tick       = (presc_reg == PRESC_MAX);
   assign count_inc  = count_reg + 32'd1;
   assign ti_set     = tick & ~wr_count & (count_inc == compare_reg);

   assign ip[1:0] = ip_sw_reg;

   // IP2..IP7 from sampled hw lines; the timer shares IP7 with the top hw line
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_ip
         if (gi < HW_IRQ) begin : g_hw
            if (gi == 5) begin : g_top
               assign ip[7] = hw_int_reg[gi] | ti_reg;
            end else begin : g_low
               assign ip[gi+2] = hw_int_reg[gi];
            end
         end else begin : g_none
            if (gi == 5) begin : g_top
               assign ip[7] = ti_reg;
            end else begin : g_low
               assign ip[gi+2] = 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg    <= '0;
         compare_reg  <= '0;
         presc_reg    <= '0;
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ti_reg       <= 1'b0;
         ip_sw_reg    <= '0;
         hw_int_reg   <= '0;
         exc_code_reg <= '0;
         epc_reg      <= '0;
      end else begin
         hw_int_reg <= hw_int;

         if (wr_count) begin
            count_reg <= wd;
            presc_reg <= '0;
         end else if (tick) begin
            count_reg <= count_inc;
            presc_reg <= '0;
         end else begin
            presc_reg <= presc_reg + 1'b1;
         end

         if (wr_compare) begin
            compare_reg <= wd;
            ti_reg      <= 1'b0;
         end else if (ti_set) begin
            ti_reg <= 1'b1;
         end

         // nested exceptions keep the original EPC/BD so ERET returns to the first fault
         if (exc_req) begin
            exc_code_reg <= exc_code;
            if (!exl_reg) begin
               epc_reg <= bd ? (pc - 32'd4) : pc;
               bd_reg  <= bd;
               exl_reg <= 1'b1;
            end
         end else if (eret) begin
            exl_reg <= 1'b0;
         end else if (wr_en) begin
            case (a1)
               5'd12: begin
                  im_reg  <= wd[15:8];
                  exl_reg <= wd[1];
                  ie_reg  <= wd[0];
               end
               5'd13:   ip_sw_reg <= wd[9:8];
               5'd14:   epc_reg   <= wd;
               default: ;
            endcase
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr_reg <= '0;
      end else if (exc_req && (exc_code == 5'd4 || exc_code == 5'd5)) begin
         badvaddr_reg <= badvaddr;
      end
   end
`endif

   always_comb begin
      rd1 = '0;
      case (a1)
`ifdef CP0_BADVADDR_EN
         5'd8:  rd1 = badvaddr_reg;
`endif
         5'd9:  rd1 = count_reg;
         5'd11: rd1 = compare_reg;
         5'd12: rd1 = {16'd0, im_reg, 6'd0, exl_reg, ie_reg};
         5'd13: rd1 = {bd_reg, ti_reg, 14'd0, ip, 1'b0, exc_code_reg, 2'b00};
         5'd14: rd1 = epc_reg;
         5'd15: rd1 = PRID_VAL;
         default: rd1 = '0;
      endcase
   end

   assign irq     = ie_reg & ~exl_reg & (|(im_reg & ip));
   assign epc_out = epc_reg;
   assign exl     = exl_reg;

endmodule

// File: tb/tb_cp0_exc.sv
// Directed bench for cp0_exc: one instance with COUNT_DIV=1/HW_IRQ=6, one with COUNT_DIV=3/HW_IRQ=2.
module tb_cp0_exc;

   localparam logic [31:0] PRID_A = 32'h0001_8000;
   localparam logic [31:0] PRID_B = 32'hCAFE_0001;

   logic        clk = 1'b0;
   logic        reset;
   logic        cp0_w;
   logic [4:0]  a1;
   logic [31:0] wd;
   logic [31:0] pc;
   logic        bd;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic        eret;
   logic [5:0]  hw_int;
   logic [31:0] badvaddr;

   logic [31:0] rd1, rd1_b;
   logic        irq, irq_b;
   logic [31:0] epc_out, epc_out_b;
   logic        exl, exl_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cp0_exc #(.HW_IRQ(6), .COUNT_DIV(1), .PRID_VAL(PRID_A)) dut (
      .clk(clk), .reset(reset), .cp0_w(cp0_w), .a1(a1), .wd(wd), .rd1(rd1),
      .pc(pc), .bd(bd), .exc_req(exc_req), .exc_code(exc_code), .eret(eret),
      .hw_int(hw_int),
`ifdef CP0_BADVADDR_EN
      .badvaddr(badvaddr),
`endif
      .irq(irq), .epc_out(epc_out), .exl(exl)
   );

   cp0_exc #(.HW_IRQ(2), .COUNT_DIV(3), .PRID_VAL(PRID_B)) dut_b (
      .clk(clk), .reset(reset), .cp0_w(cp0_w), .a1(a1), .wd(wd), .rd1(rd1_b),
      .pc(pc), .bd(bd), .exc_req(exc_req), .exc_code(exc_code), .eret(eret),
      .hw_int(hw_int[1:0]),
`ifdef CP0_BADVADDR_EN
      .badvaddr(badvaddr),
`endif
      .irq(irq_b), .epc_out(epc_out_b), .exl(exl_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] r);
      a1 = r;
      #1;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
      $display("mtc0 r%0d <= %h", r, d);
      a1 = r;
      wd = d;
      cp0_w = 1'b1;
      tick();
      cp0_w = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1; cp0_w = 1'b0; a1 = '0; wd = '0; pc = '0; bd = 1'b0;
      exc_req = 1'b0; exc_code = '0; eret = 1'b0; hw_int = '0; badvaddr = '0;

      // reset state and register map
      repeat (3) tick();
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i);
         #1;
         chk($sformatf("reset_rd1_r%0d", i), rd1, (i == 15) ? PRID_A : 32'd0);
      end
      a1 = 5'd15; #1;
      chk("reset_prid_b", rd1_b, PRID_B);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      chk("reset_exl", {31'd0, exl}, 32'd0);
      chk("reset_epc", epc_out, 32'd0);
      tick();
      reset = 1'b0;

      // Count prescaling: 7 edges -> 7 at div 1, 2 at div 3
      repeat (7) tick();
      rd(5'd9);
      chk("count_div1", rd1, 32'd7);
      chk("count_div3", rd1_b, 32'd2);

      // Status write, old value visible during the write cycle
      a1 = 5'd12; wd = 32'h0000_0401; cp0_w = 1'b1; #1;
      chk("status_old_in_wr", rd1, 32'd0);
      tick();
      cp0_w = 1'b0;
      $display("mtc0 r12 <= 00000401");
      rd(5'd12);
      chk("status_new", rd1, 32'h0000_0401);
      chk("status_new_b", rd1_b, 32'h0000_0401);

      // hw interrupt: one cycle of lag
      hw_int = 6'h01;
      rd(5'd13);
      chk("cause_before_hw", rd1, 32'd0);
      chk("irq_before_hw", {31'd0, irq}, 32'd0);
      tick();
      rd(5'd13);
      chk("cause_hw0", rd1, 32'h0000_0400);
      chk("irq_hw0", {31'd0, irq}, 32'd1);
      chk("cause_hw0_b", rd1_b, 32'h0000_0400);
      chk("irq_hw0_b", {31'd0, irq_b}, 32'd1);
      hw_int = 6'h3F;
      tick();
      rd(5'd13);
      chk("cause_hw_all", rd1, 32'h0000_FC00);
      chk("cause_hw_all_b", rd1_b, 32'h0000_0C00);
      hw_int = 6'h01;
      tick();

      // exception in delay slot, nested exception, ERET
      $display("exc pc=00400010 bd=1 code=8");
      pc = 32'h0040_0010; bd = 1'b1; exc_code = 5'd8; exc_req = 1'b1;
      tick();
      exc_req = 1'b0; bd = 1'b0;
      chk("exc1_epc_out", epc_out, 32'h0040_000C);
      chk("exc1_exl", {31'd0, exl}, 32'd1);
      chk("exc1_irq", {31'd0, irq}, 32'd0);
      rd(5'd13);
      chk("exc1_cause", rd1, 32'h8000_0420);
      rd(5'd14);
      chk("exc1_epc_rd", rd1, 32'h0040_000C);

      $display("exc pc=00400100 bd=0 code=10 (nested)");
      pc = 32'h0040_0100; exc_code = 5'd10; exc_req = 1'b1;
      tick();
      exc_req = 1'b0;
      chk("exc2_epc_held", epc_out, 32'h0040_000C);
      rd(5'd13);
      chk("exc2_cause", rd1, 32'h8000_0428);
      rd(5'd12);
      chk("exc2_status", rd1, 32'h0000_0403);

      $display("eret");
      eret = 1'b1;
      tick();
      eret = 1'b0;
      chk("eret_exl", {31'd0, exl}, 32'd0);
      chk("eret_irq", {31'd0, irq}, 32'd1);
      rd(5'd12);
      chk("eret_status", rd1, 32'h0000_0401);
      hw_int = 6'h00;
      tick();

      // timer match at div 1
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      repeat (4) tick();
      rd(5'd9);
      chk("count_pre_match", rd1, 32'd4);
      rd(5'd13);
      chk("cause_pre_match", rd1, 32'h8000_0028);
      tick();
      rd(5'd9);
      chk("count_match", rd1, 32'd5);
      chk("count_b_after_load", rd1_b, 32'd1);
      rd(5'd13);
      chk("cause_ti", rd1, 32'hC000_8028);
      chk("cause_no_ti_b", rd1_b, 32'h8000_0028);
      mtc0(5'd11, 32'd9);
      rd(5'd13);
      chk("cause_ti_cleared", rd1, 32'h8000_0028);
      rd(5'd9);
      chk("count_after_cmp_wr", rd1, 32'd6);
      repeat (2) tick();
      mtc0(5'd11, 32'd9);
      rd(5'd9);
      chk("count_clear_wins", rd1, 32'd9);
      rd(5'd13);
      chk("cause_clear_wins", rd1, 32'h8000_0028);
      mtc0(5'd9, 32'd7);
      repeat (2) tick();
      rd(5'd13);
      chk("cause_ti_again", rd1, 32'hC000_8028);
      mtc0(5'd11, 32'd0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      tick();
      rd(5'd9);
      chk("count_wrap", rd1, 32'd0);
      rd(5'd13);
      chk("cause_ti_wrap", rd1, 32'hC000_8028);
      mtc0(5'd11, 32'h0000_1000);
      rd(5'd13);
      chk("cause_ti_clr2", rd1, 32'h8000_0028);

      // mtc0 EPC colliding with exception is dropped
      $display("exc pc=00000100 bd=0 code=0 with mtc0 r14 <= deadbeef");
      a1 = 5'd14; wd = 32'hDEAD_BEEF; cp0_w = 1'b1;
      pc = 32'h0000_0100; bd = 1'b0; exc_code = 5'd0; exc_req = 1'b1;
      tick();
      cp0_w = 1'b0; exc_req = 1'b0;
      chk("drop_epc_out", epc_out, 32'h0000_0100);
      chk("drop_exl", {31'd0, exl}, 32'd1);
      rd(5'd14);
      chk("drop_epc_rd", rd1, 32'h0000_0100);
      rd(5'd13);
      chk("drop_cause", rd1, 32'd0);

      $display("eret with mtc0 r12 <= 0");
      a1 = 5'd12; wd = 32'd0; cp0_w = 1'b1; eret = 1'b1;
      tick();
      cp0_w = 1'b0; eret = 1'b0;
      chk("eret_drop_exl", {31'd0, exl}, 32'd0);
      rd(5'd12);
      chk("eret_drop_status", rd1, 32'h0000_0401);

      mtc0(5'd14, 32'h0000_1234);
      rd(5'd14);
      chk("epc_write", rd1, 32'h0000_1234);
      mtc0(5'd15, 32'd0);
      rd(5'd15);
      chk("prid_ro", rd1, PRID_A);

`ifdef CP0_BADVADDR_EN
      $display("exc code=4 badvaddr=12345671");
      exc_code = 5'd4; badvaddr = 32'h1234_5671; exc_req = 1'b1;
      tick();
      exc_req = 1'b0;
      rd(5'd8);
      chk("badvaddr_load", rd1, 32'h1234_5671);
      $display("exc code=8 badvaddr=ffff0000");
      exc_code = 5'd8; badvaddr = 32'hFFFF_0000; exc_req = 1'b1;
      tick();
      exc_req = 1'b0;
      rd(5'd8);
      chk("badvaddr_held", rd1, 32'h1234_5671);
`else
      rd(5'd8);
      chk("badvaddr_absent", rd1, 32'd0);
`endif

      // reset during an exception
      $display("exc pc=00000200 then reset");
      pc = 32'h0000_0200; exc_code = 5'd3; exc_req = 1'b1;
      tick();
      exc_req = 1'b0;
      chk("pre_reset_exl", {31'd0, exl}, 32'd1);
      reset = 1'b1;
      tick();
      chk("rst_exl", {31'd0, exl}, 32'd0);
      chk("rst_epc", epc_out, 32'd0);
      rd(5'd9);
      chk("rst_count", rd1, 32'd0);
      rd(5'd12);
      chk("rst_status", rd1, 32'd0);
      rd(5'd13);
      chk("rst_cause", rd1, 32'd0);
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
